d_sram_to_sram_like: RTL



---
 rtl/d_sram_to_sram_like.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/d_sram_to_sram_like.sv
// d_sram_to_sram_like
// Data-side bridge from the core's single-cycle SRAM data port to the
// sram-like data port of cpu_axi_interface. Each MEM-stage access becomes
// one registered sram-like transaction. The pipeline is stalled until the
// response returns. The response is then held until the whole pipeline
// advances, so one memory instruction is never issued twice.
//
// Ports
//   clk, rst            core clock; synchronous active-high reset
//   data_sram_*         core side: en, wen (0000 = load), addr, wdata, rdata
//   d_stall             stall request to the hazard unit (combinational)
//   longest_stall       global pipeline stall; releases the DONE state
//   data_req/wr/size/addr/wdata   sram-like request (all registered)
//   data_rdata, data_addr_ok, data_data_ok   sram-like response
//   dbg_state           current FSM state (0 IDLE, 1 REQ, 2 WAIT, 3 DONE)
//
// Handshake: data_req stays high from REQ entry until the cycle in which
// data_addr_ok is sampled high. The request fields do not change during that
// window and the request is never withdrawn. data_data_ok may arrive in the
// same cycle as data_addr_ok or in any later cycle. data_data_ok is only
// honoured once the request has been accepted.
//
// Build option: define D_BRIDGE_KSEG_MAP_EN to translate kseg0/kseg1 virtual
// addresses (0x8000_0000-0xBFFF_FFFF) to physical by clearing bits [31:29].
// All other addresses pass through unchanged.
module d_sram_to_sram_like (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        d_stall,
  input  logic        longest_stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic [31:0] data_rdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state;
  logic [1:0]  req_size;
  logic [1:0]  req_low;
  logic [31:0] phys_addr;
  logic [31:0] req_addr;
  logic        resp_hit;

  // Byte enables to sram-like size and byte offset. Loads always fetch the
  // whole word, because the core extracts bytes and halfwords itself.
  // Enable patterns outside the legal set are treated as a full-word store.
  always_comb begin
    req_size = 2'd2;
    req_low  = 2'b00;
    case (data_sram_wen)
      4'b0001: begin req_size = 2'd0; req_low = 2'b00; end
      4'b0010: begin req_size = 2'd0; req_low = 2'b01; end
      4'b0100: begin req_size = 2'd0; req_low = 2'b10; end
      4'b1000: begin req_size = 2'd0; req_low = 2'b11; end
      4'b0011: begin req_size = 2'd1; req_low = 2'b00; end
      4'b1100: begin req_size = 2'd1; req_low = 2'b10; end
      default: begin req_size = 2'd2; req_low = 2'b00; end
    endcase
  end

`ifdef D_BRIDGE_KSEG_MAP_EN
  // kseg0/kseg1 are unmapped windows onto the low 512 MB of physical memory.
  assign phys_addr = (data_sram_addr[31:30] == 2'b10) ?
                     {3'b000, data_sram_addr[28:0]} : data_sram_addr;
`else
  assign phys_addr = data_sram_addr;
`endif

  assign req_addr = (phys_addr & 32'hFFFF_FFFC) | {30'd0, req_low};

  // A response counts only after the request has been accepted. It is
  // accepted either earlier (WAIT) or in this very cycle (REQ with addr_ok).
  assign resp_hit = data_data_ok &
                    (((state == S_REQ) & data_addr_ok) | (state == S_WAIT));

  // DONE is excluded: the instruction is already serviced there, so the
  // bridge must not stall it again while a foreign stall is in effect.
  assign d_stall   = rst ? 1'b0 : (data_sram_en & (state != S_DONE));
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      data_req        <= 1'b0;
      data_wr         <= 1'b0;
      data_size       <= 2'd0;
      data_addr       <= 32'd0;
      data_wdata      <= 32'd0;
      data_sram_rdata <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (data_sram_en) begin
            data_req   <= 1'b1;
            data_wr    <= |data_sram_wen;
            data_size  <= req_size;
            data_addr  <= req_addr;
            data_wdata <= data_sram_wdata;
            state      <= S_REQ;
          end
        end
        S_REQ: begin
          if (data_addr_ok) begin
            data_req <= 1'b0;
            state    <= data_data_ok ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (data_data_ok) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          // Held until the whole pipeline moves, so that the same
          // instruction cannot re-enter IDLE and issue again.
          if (!longest_stall) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Only read responses update the returned data. A write response
      // leaves the last loaded word in place.
      if (resp_hit && !data_wr) begin
        data_sram_rdata <= data_rdata;
      end
    end
  end

endmodule
